uart_cmd_ctrl: RTL and testbench

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

---
 rtl/uart_cmd_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
// Collects a three-byte command (operand A, operand B, opcode) from a UART
// receiver. It presents the operands and opcode to an external combinational
// ALU, captures the result, and requests exactly one transmit of it. An
// inter-byte timeout abandons partial commands. Bytes arriving while a result
// is executed or sent are dropped.
//
// state   | meaning
// --------+--------------------------------------------------------------
// WAIT_A  | idle; next accepted byte is operand A (no timeout)
// WAIT_B  | operand A held; waiting for operand B, timeout armed
// WAIT_OP | operands held; waiting for opcode byte, timeout armed
// EXEC    | ALU inputs stable for one cycle; result captured at its end
// SEND    | o_tx_start high for this single cycle
// WAIT_TX | transmitter busy; leave on i_tx_done (no timeout)

module uart_cmd_ctrl #(
    parameter int unsigned NB_DATA     = 8,
    parameter int unsigned NB_OP       = 6,
    parameter logic [31:0] TIMEOUT_CYC = 32'd1000000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_err,
    output logic               o_drop
);

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    // Counter value at which the waiting state gives up; the counter starts
    // at 0 in the first cycle after entry, so this expires TIMEOUT_CYC cycles
    // after entering WAIT_B or WAIT_OP.
    localparam logic [31:0] TMO_LAST = TIMEOUT_CYC - 32'd1;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic        tmo_hit;
    logic        ld_a;
    logic        ld_b;
    logic        ld_op;
    logic        ld_tx;
    logic        err_d;
    logic        drop_d;
    logic        busy_d;
    logic        tx_start_d;

    assign tmo_hit = (cnt_q == TMO_LAST);

    // Next-state, counter and load-enable decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        ld_a       = 1'b0;
        ld_b       = 1'b0;
        ld_op      = 1'b0;
        ld_tx      = 1'b0;
        err_d      = 1'b0;
        drop_d     = 1'b0;

        case (state_q)
            ST_WAIT_A: begin
                if (i_rx_valid) begin
                    ld_a    = 1'b1;
                    state_d = ST_WAIT_B;
                end
            end

            ST_WAIT_B: begin
                // A byte that lands on the expiry cycle still wins.
                if (i_rx_valid) begin
                    ld_b    = 1'b1;
                    state_d = ST_WAIT_OP;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT_A;
                end else begin
                    cnt_d   = cnt_q + 32'd1;
                end
            end

            ST_WAIT_OP: begin
                if (i_rx_valid) begin
                    ld_op   = 1'b1;
                    state_d = ST_EXEC;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT_A;
                end else begin
                    cnt_d   = cnt_q + 32'd1;
                end
            end

            ST_EXEC: begin
                ld_tx   = 1'b1;
                drop_d  = i_rx_valid;
                state_d = ST_SEND;
            end

            ST_SEND: begin
                drop_d  = i_rx_valid;
                state_d = ST_WAIT_TX;
            end

            ST_WAIT_TX: begin
                drop_d = i_rx_valid;
                if (i_tx_done) begin
                    state_d = ST_WAIT_A;
                end
            end

            default: begin
                state_d = ST_WAIT_A;
            end
        endcase

        tx_start_d = (state_d == ST_SEND);
        busy_d     = (state_d == ST_EXEC) || (state_d == ST_SEND) ||
                     (state_d == ST_WAIT_TX);
    end

    // Registered control: the pulses and the busy flag are computed from the
    // next state, so they line up exactly with the state they describe.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_WAIT_A;
            cnt_q      <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
            o_drop     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            o_tx_start <= tx_start_d;
            o_busy     <= busy_d;
            o_err      <= err_d;
            o_drop     <= drop_d;
        end
    end

    // Operand, opcode and result registers; each holds until reloaded.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_data_a  <= '0;
            o_data_b  <= '0;
            o_op      <= '0;
            o_tx_data <= '0;
        end else begin
            if (ld_a) begin
                o_data_a <= i_rx_data;
            end
            if (ld_b) begin
                o_data_b <= i_rx_data;
            end
            if (ld_op) begin
                o_op <= i_rx_data[NB_OP-1:0];
            end
            if (ld_tx) begin
                o_tx_data <= i_alu_result;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl
// Drives directed and randomized commands into uart_cmd_ctrl. The external
// ALU is modelled behaviourally. Expected register contents and pulse
// timing are tracked at command level.

module tb_uart_cmd_ctrl;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int TMO     = 16;

    logic               i_clk = 1'b0;
    logic               i_reset = 1'b1;
    logic [NB_DATA-1:0] i_rx_data = '0;
    logic               i_rx_valid = 1'b0;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done = 1'b0;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_err;
    logic               o_drop;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] exp_a  = '0;
    logic [7:0] exp_b  = '0;
    logic [5:0] exp_op = '0;
    logic [7:0] exp_tx = '0;

    uart_cmd_ctrl #(
        .NB_DATA     (NB_DATA),
        .NB_OP       (NB_OP),
        .TIMEOUT_CYC (32'(TMO))
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .i_alu_result (i_alu_result),
        .i_tx_done    (i_tx_done),
        .o_data_a     (o_data_a),
        .o_data_b     (o_data_b),
        .o_op         (o_op),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .o_busy       (o_busy),
        .o_err        (o_err),
        .o_drop       (o_drop)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign i_alu_result = alu_ref(o_data_a, o_data_b, o_op);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        step();
        i_rx_valid = 1'b0;
        i_rx_data  = 8'($urandom);
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_a"},  64'(o_data_a),  64'(exp_a));
        chk({tag, "_b"},  64'(o_data_b),  64'(exp_b));
        chk({tag, "_op"}, 64'(o_op),      64'(exp_op));
        chk({tag, "_tx"}, 64'(o_tx_data), 64'(exp_tx));
    endtask

    // Idle cycles with no byte; optional stray i_tx_done pulses.
    task automatic idle_chk(input int n, input logic want_busy, input bit stray_done);
        for (int i = 0; i < n; i++) begin
            i_tx_done = stray_done ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            i_tx_done = 1'b0;
            chk("idle_err", 64'(o_err), 64'(0));
            chk("idle_busy", 64'(o_busy), 64'(want_busy));
            chk("idle_start", 64'(o_tx_start), 64'(0));
        end
    endtask

    // Full command. drop_phase: 0 none, 1 byte in EXEC, 2 in SEND, 3 in WAIT_TX.
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input int gap_ab, input int gap_bo, input int drop_phase,
                           input int wait_tx);
        send_byte(a);
        exp_a = a;
        chk("acc_a", 64'(o_data_a), 64'(exp_a));
        chk("wb_busy", 64'(o_busy), 64'(0));
        idle_chk(gap_ab, 1'b0, 1'b1);
        send_byte(b);
        exp_b = b;
        chk("acc_b", 64'(o_data_b), 64'(exp_b));
        chk("acc_b_err", 64'(o_err), 64'(0));
        idle_chk(gap_bo, 1'b0, 1'b1);
        send_byte(opb);
        exp_op = opb[5:0];
        // EXEC
        chk_regs("exec");
        chk("exec_busy", 64'(o_busy), 64'(1));
        chk("exec_start", 64'(o_tx_start), 64'(0));
        chk("exec_err", 64'(o_err), 64'(0));
        exp_tx = alu_ref(exp_a, exp_b, exp_op);
        if (drop_phase == 1) begin
            i_rx_valid = 1'b1;
            i_rx_data  = 8'($urandom);
        end
        step();
        i_rx_valid = 1'b0;
        // SEND
        chk("send_start", 64'(o_tx_start), 64'(1));
        chk("send_tx", 64'(o_tx_data), 64'(exp_tx));
        chk("send_busy", 64'(o_busy), 64'(1));
        chk("send_drop", 64'(o_drop), 64'(drop_phase == 1));
        if (drop_phase == 2) begin
            i_rx_valid = 1'b1;
            i_rx_data  = 8'($urandom);
        end
        step();
        i_rx_valid = 1'b0;
        // WAIT_TX
        chk("wtx_start", 64'(o_tx_start), 64'(0));
        chk("wtx_busy", 64'(o_busy), 64'(1));
        chk("wtx_drop", 64'(o_drop), 64'(drop_phase == 2));
        for (int i = 0; i < wait_tx; i++) begin
            if (drop_phase == 3 && i == 0) begin
                i_rx_valid = 1'b1;
                i_rx_data  = 8'h77;
            end
            step();
            i_rx_valid = 1'b0;
            chk("wtx_loop_drop", 64'(o_drop), 64'(drop_phase == 3 && i == 0));
            chk("wtx_loop_busy", 64'(o_busy), 64'(1));
            chk("wtx_loop_start", 64'(o_tx_start), 64'(0));
            chk("wtx_loop_err", 64'(o_err), 64'(0));
        end
        chk_regs("wtx");
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        chk("done_busy", 64'(o_busy), 64'(0));
        chk("done_start", 64'(o_tx_start), 64'(0));
        chk("done_drop", 64'(o_drop), 64'(0));
    endtask

    logic [7:0] op_list [6] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27};

    initial begin
        // Asynchronous reset before any clock edge.
        #2 i_reset = 1'b0;
        #1;
        chk("rst_a", 64'(o_data_a), 64'(0));
        chk("rst_b", 64'(o_data_b), 64'(0));
        chk("rst_op", 64'(o_op), 64'(0));
        chk("rst_tx", 64'(o_tx_data), 64'(0));
        chk("rst_start", 64'(o_tx_start), 64'(0));
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_err", 64'(o_err), 64'(0));
        chk("rst_drop", 64'(o_drop), 64'(0));
        step();
        step();
        i_reset = 1'b1;
        step();

        // Basic ADD command; result pulse two edges after opcode byte.
        run_cmd(8'h05, 8'h03, 8'h20, 0, 0, 0, 2);
        chk("add_result", 64'(o_tx_data), 64'(8'h08));

        // Timeout in WAIT_B: o_err exactly TMO cycles after entering WAIT_B.
        send_byte(8'hAA);
        exp_a = 8'hAA;
        for (int i = 1; i <= TMO; i++) begin
            step();
            chk("tmo_b_err", 64'(o_err), 64'(i == TMO));
        end
        step();
        chk("tmo_b_err_clr", 64'(o_err), 64'(0));
        chk_regs("tmo_b_hold");
        // Back in WAIT_A: the next byte must become operand A.
        send_byte(8'h11);
        exp_a = 8'h11;
        chk("after_tmo_a", 64'(o_data_a), 64'(exp_a));
        chk("after_tmo_b", 64'(o_data_b), 64'(exp_b));

        // Timeout in WAIT_OP.
        send_byte(8'h22);
        exp_b = 8'h22;
        idle_chk(TMO - 1, 1'b0, 1'b0);
        step();
        chk("tmo_op_err", 64'(o_err), 64'(1));
        chk("tmo_op_busy", 64'(o_busy), 64'(0));
        step();
        chk("tmo_op_err_clr", 64'(o_err), 64'(0));
        chk_regs("tmo_op_hold");

        // Byte exactly on the expiry cycle is accepted, both waiting states.
        run_cmd(8'h40, 8'h0F, 8'hE4, TMO - 1, TMO - 1, 0, 1);

        // No timeout in WAIT_A or WAIT_TX.
        idle_chk(3 * TMO, 1'b0, 1'b1);
        run_cmd(8'h9C, 8'h31, 8'h26, 2, 3, 3, 3 * TMO);

        // Reset while in SEND.
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h20);
        step();
        chk("pre_rst_start", 64'(o_tx_start), 64'(1));
        #2 i_reset = 1'b0;
        #1;
        chk("mid_rst_start", 64'(o_tx_start), 64'(0));
        chk("mid_rst_busy", 64'(o_busy), 64'(0));
        chk("mid_rst_a", 64'(o_data_a), 64'(0));
        chk("mid_rst_b", 64'(o_data_b), 64'(0));
        chk("mid_rst_op", 64'(o_op), 64'(0));
        chk("mid_rst_tx", 64'(o_tx_data), 64'(0));
        exp_a = '0; exp_b = '0; exp_op = '0; exp_tx = '0;
        step();
        step();
        i_reset = 1'b1;
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        chk("post_rst_busy", 64'(o_busy), 64'(0));
        idle_chk(5, 1'b0, 1'b1);
        chk_regs("post_rst");

        // Randomized commands with gaps, stray tx_done and dropped bytes.
        for (int n = 0; n < 30; n++) begin
            logic [7:0] opb;
            opb = {2'($urandom), op_list[$urandom_range(0, 5)][5:0]};
            run_cmd(8'($urandom), 8'($urandom), opb,
                    $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1),
                    $urandom_range(0, 3), $urandom_range(1, 6));
            chk("rnd_result", 64'(o_tx_data), 64'(alu_ref(exp_a, exp_b, opb[5:0])));
            idle_chk($urandom_range(0, 4), 1'b0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
